// File: rtl/regfile_scoreboard.sv
// Register file (2 async reads, 1 sync write) with a per-register pending scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rd1_addr,
    output logic [DW-1:0] rd1_data,
    output logic          rd1_busy,
    input  logic [AW-1:0] rd2_addr,
    output logic [DW-1:0] rd2_data,
    output logic          rd2_busy,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    output logic          claim_busy,
    output logic [AW:0]   pending_count
);
    localparam int NREG = 1 << AW;
    localparam int NRD  = 2;

    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0]         busy;
    logic [NRD-1:0][AW-1:0]  rd_addr;
    logic                    wr_ok;
    logic                    claim_ok;
    logic                    set_pend;
    logic                    clr_pend;
    logic [AW:0]             count_next;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok    = wr_en && !is_zero(wr_addr);
    assign claim_ok = claim_en && !is_zero(claim_addr);

    // Reg 0 is never claimed when hard-wired, so its busy bit stays 0.
    assign claim_busy = busy[claim_addr];

    // Count tracks popcount(busy) incrementally; a same-address claim
    // masks the clear so the count cannot dip and recover.
    assign set_pend   = claim_ok && !busy[claim_addr];
    assign clr_pend   = wr_ok && busy[wr_addr] && !(claim_ok && (claim_addr == wr_addr));
    assign count_next = pending_count + {{AW{1'b0}}, set_pend} - {{AW{1'b0}}, clr_pend};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs          <= '0;
            busy          <= '0;
            pending_count <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // Claim after write so a same-edge claim wins the busy bit.
            if (claim_ok) busy[claim_addr] <= 1'b1;
            pending_count <= count_next;
        end
    end

    assign rd_addr = {rd2_addr, rd1_addr};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [DW-1:0] data;
        logic          bsy;
        always_comb begin
            data = regs[rd_addr[p]];
            bsy  = busy[rd_addr[p]];
            if (is_zero(rd_addr[p])) begin
                data = '0;
                bsy  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (reset && wr_ok && (wr_addr == rd_addr[p])) begin
                data = wr_data;
                bsy  = 1'b0;
            end
`endif
        end
    end

    assign rd1_data = g_rd[0].data;
    assign rd1_busy = g_rd[0].bsy;
    assign rd2_data = g_rd[1].data;
    assign rd2_busy = g_rd[1].bsy;

endmodule
